boot_copier: RTL

- Parametrised successor to the boot memory copier used by the bootstrap MMU.
- After reset, or on request, it takes ownership of the shared address bus and copies one or more EEPROM address regions into RAM at the same addresses. Data flows EEPROM→RAM directly on the shared data bus.
- Adds multiple regions, programmable strobe timing, an optional read-back verify pass with error capture, and re-triggering.
- On completion it releases the bus and raises done, which gates the peripheral chip enables at top level.

---
 rtl/boot_copier_pkg.sv | 29 ++
 rtl/boot_copier_copy_phase_timer.sv | 34 +++
 rtl/boot_copier.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/boot_copier_pkg.sv
// Shared definitions for the boot memory copier: state encoding, default
// phase timing and the packed region-vector accessor.
package boot_copier_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_SETUP  = 3'd1;
    localparam state_t S_WRITE  = 3'd2;
    localparam state_t S_HOLD   = 3'd3;
    localparam state_t S_VERIFY = 3'd4;
    localparam state_t S_DONE   = 3'd5;

    localparam int DEF_SETUP_CYCLES = 1;
    localparam int DEF_WE_CYCLES    = 1;
    localparam int DEF_HOLD_CYCLES  = 1;
    localparam int DEF_READ_CYCLES  = 1;

    localparam int TIMER_W   = 16;
    localparam int MAX_VEC_W = 256;

    // Field idx of a packed vector of width-bit entries, entry 0 in the LSBs.
    function automatic logic [31:0] region_field(input logic [MAX_VEC_W-1:0] vec,
                                                 input int unsigned idx,
                                                 input int unsigned width);
        region_field = 32'(vec >> (idx * width)) & ((32'h1 << width) - 32'h1);
    endfunction

endpackage

// File: rtl/boot_copier_copy_phase_timer.sv
// Loadable phase down-counter; last is high in the final cycle of a phase
// loaded with a cycle count of load_value.
module copy_phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             last
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value - CNT_W'(1);
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last = (count_q == '0);

endmodule

// File: rtl/boot_copier.sv
// Copies EEPROM address regions into RAM at the same addresses over the shared
// bus, with optional read-back verify, then releases the bus and raises done.
module boot_copier
    import boot_copier_pkg::*;
#(
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_REGIONS   = 1,
    parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_START = {NUM_REGIONS{ADDR_WIDTH'(16'h8000)}},
    parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_END   = '1,
    parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
    parameter int WE_CYCLES     = DEF_WE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int VERIFY        = 0,
    parameter int READ_CYCLES   = DEF_READ_CYCLES,
    parameter int AUTO_START    = 1,
    parameter int STOP_ON_ERROR = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [ADDR_WIDTH-1:0] address_out,
    output logic                  bus_oe,
    output logic                  ram_we_n,
    output logic                  ram_oe_n,
    output logic                  ram_cs_n,
    output logic                  eeprom_oe_n,
    output logic                  eeprom_cs_n,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] error_address
);

    localparam logic [MAX_VEC_W-1:0] START_VEC = MAX_VEC_W'(REGION_START);
    localparam logic [MAX_VEC_W-1:0] END_VEC   = MAX_VEC_W'(REGION_END);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   err_addr_q, err_addr_d;
    logic [3:0]              reg_q, reg_d;
    logic [DATA_WIDTH-1:0]   expect_q, expect_d;
    logic                    error_q, error_d;
    logic                    auto_start_q, auto_start_d;

    logic                    in_copy, go, byte_end, mismatch;
    logic                    seek_found;
    logic [3:0]              seek_idx;
    logic [ADDR_WIDTH-1:0]   seek_start, cur_end;
    logic [ADDR_WIDTH-1:0]   rstart [NUM_REGIONS];
    logic [ADDR_WIDTH-1:0]   rend   [NUM_REGIONS];

    logic                    t_load, t_last;
    logic [TIMER_W-1:0]      t_value;

    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
        assign rstart[g] = ADDR_WIDTH'(region_field(START_VEC, g, ADDR_WIDTH));
        assign rend[g]   = ADDR_WIDTH'(region_field(END_VEC, g, ADDR_WIDTH));
    end

    assign in_copy = (state_q == S_SETUP) || (state_q == S_WRITE) ||
                     (state_q == S_HOLD)  || (state_q == S_VERIFY);

    // Next non-empty region: from region 0 when starting, else after the current one.
    always_comb begin
        seek_found = 1'b0;
        seek_idx   = '0;
        seek_start = '0;
        cur_end    = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (4'(i) == reg_q) begin
                cur_end = rend[i];
            end
            if (!seek_found && (!in_copy || (4'(i) > reg_q)) && (rstart[i] <= rend[i])) begin
                seek_found = 1'b1;
                seek_idx   = 4'(i);
                seek_start = rstart[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        reg_d        = reg_q;
        expect_d     = expect_q;
        error_d      = error_q;
        err_addr_d   = err_addr_q;
        auto_start_d = 1'b0;
        go           = 1'b0;
        byte_end     = 1'b0;
        mismatch     = (data_in != expect_q);

        case (state_q)
            S_IDLE:  go = start || auto_start_q;
            S_SETUP: begin
                if (t_last) begin
                    expect_d = data_in;
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                if (t_last) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (t_last) begin
                    if (VERIFY != 0) state_d = S_VERIFY;
                    else             byte_end = 1'b1;
                end
            end
            S_VERIFY: begin
                if (t_last) begin
                    if (mismatch && !error_q) begin
                        error_d    = 1'b1;
                        err_addr_d = addr_q;
                    end
                    if (mismatch && (STOP_ON_ERROR != 0)) state_d = S_DONE;
                    else                                  byte_end = 1'b1;
                end
            end
            S_DONE:  go = start;
            default: state_d = S_IDLE;
        endcase

        if (go) begin
            error_d    = 1'b0;
            err_addr_d = '0;
        end

        // End test precedes the increment so an all-ones end never wraps.
        if (byte_end && (addr_q != cur_end)) begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = S_SETUP;
        end else if (go || byte_end) begin
            if (seek_found) begin
                reg_d   = seek_idx;
                addr_d  = seek_start;
                state_d = S_SETUP;
            end else begin
                state_d = S_DONE;
            end
        end
    end

    // Every phase change reloads the timer with the duration of the phase entered.
    always_comb begin
        case (state_d)
            S_SETUP:  t_value = TIMER_W'(SETUP_CYCLES);
            S_WRITE:  t_value = TIMER_W'(WE_CYCLES);
            S_HOLD:   t_value = TIMER_W'(HOLD_CYCLES);
            S_VERIFY: t_value = TIMER_W'(READ_CYCLES);
            default:  t_value = '0;
        endcase
        t_load = (state_d != state_q) && (t_value != '0);
    end

    copy_phase_timer #(.CNT_W(TIMER_W)) u_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (t_load),
        .load_value (t_value),
        .last       (t_last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            reg_q        <= '0;
            error_q      <= 1'b0;
            err_addr_q   <= '0;
            auto_start_q <= (AUTO_START != 0);
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            reg_q        <= reg_d;
            error_q      <= error_d;
            err_addr_q   <= err_addr_d;
            auto_start_q <= auto_start_d;
        end
    end

    always_ff @(posedge clock) begin
        expect_q <= expect_d;
    end

    assign bus_oe        = in_copy;
    assign busy          = in_copy;
    assign done          = (state_q == S_DONE);
    assign address_out   = in_copy ? addr_q : '0;
    assign ram_cs_n      = !in_copy;
    assign ram_we_n      = (state_q != S_WRITE);
    assign ram_oe_n      = (state_q != S_VERIFY);
    assign eeprom_cs_n   = !((state_q == S_SETUP) || (state_q == S_WRITE) || (state_q == S_HOLD));
    assign eeprom_oe_n   = eeprom_cs_n;
    assign error         = error_q;
    assign error_address = err_addr_q;

endmodule
